// File: rtl/argmax_classifier.sv
// Sequential argmax over NUM_CLASSES signed scores: latch on start, compare one per cycle, pulse done.
// Optional runner-up margin/low-confidence outputs are enabled by defining ARGMAX_RUNNERUP_EN.
module argmax_classifier #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned MARGIN_TH   = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [3:0]                     class_idx_o,
`ifdef ARGMAX_RUNNERUP_EN
    output logic [SCORE_W:0]               margin_o,
    output logic                           low_conf_o,
`endif
    output logic [SCORE_W-1:0]             max_score_o
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e             state_q;
    logic [SCORE_W-1:0] scores_q [NUM_CLASSES];
    logic [SCORE_W-1:0] best_q;
    logic [3:0]         best_idx_q;
    logic [3:0]         idx_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         class_idx_q;
    logic [SCORE_W-1:0] max_score_q;

    logic [SCORE_W-1:0] cand;
    logic               cand_gt_best;
    logic [SCORE_W-1:0] best_d;
    logic [3:0]         best_idx_d;
    logic               scan_last;
    logic               accept;

`ifdef ARGMAX_RUNNERUP_EN
    logic [SCORE_W-1:0] second_q;
    logic [SCORE_W-1:0] second_d;
    logic [SCORE_W:0]   margin_d;
    logic [SCORE_W:0]   margin_q;
    logic               low_conf_q;
`endif

    always_comb begin
        cand         = scores_q[idx_q];
        cand_gt_best = $signed(cand) > $signed(best_q);
        best_d       = cand_gt_best ? cand : best_q;
        best_idx_d   = cand_gt_best ? idx_q : best_idx_q;
        scan_last    = (idx_q == 4'(NUM_CLASSES - 1));
        // A new scan may begin from IDLE or straight out of DONE, never mid-scan.
        accept       = start_i && (state_q != StScan);
`ifdef ARGMAX_RUNNERUP_EN
        second_d = second_q;
        if (cand_gt_best) begin
            second_d = best_q;
        end else if ($signed(cand) > $signed(second_q)) begin
            second_d = cand;
        end
        margin_d = {best_d[SCORE_W-1], best_d} - {second_d[SCORE_W-1], second_d};
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                scores_q[k] <= '0;
            end
            best_q      <= '0;
            best_idx_q  <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_idx_q <= '0;
            max_score_q <= '0;
`ifdef ARGMAX_RUNNERUP_EN
            second_q    <= '0;
            margin_q    <= '0;
            low_conf_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: ;
                StScan: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    idx_q      <= idx_q + 4'd1;
`ifdef ARGMAX_RUNNERUP_EN
                    second_q   <= second_d;
`endif
                    if (scan_last) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        class_idx_q <= best_idx_d;
                        max_score_q <= best_d;
`ifdef ARGMAX_RUNNERUP_EN
                        margin_q    <= margin_d;
                        low_conf_q  <= (margin_d < (SCORE_W + 1)'(MARGIN_TH));
`endif
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (accept) begin
                for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                    scores_q[k] <= scores_i[k*SCORE_W +: SCORE_W];
                end
                best_q     <= scores_i[SCORE_W-1:0];
                best_idx_q <= '0;
                idx_q      <= 4'd1;
                state_q    <= StScan;
                busy_q     <= 1'b1;
`ifdef ARGMAX_RUNNERUP_EN
                second_q   <= {1'b1, {(SCORE_W - 1){1'b0}}};
`endif
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign class_idx_o = class_idx_q;
    assign max_score_o = max_score_q;
`ifdef ARGMAX_RUNNERUP_EN
    assign margin_o    = margin_q;
    assign low_conf_o  = low_conf_q;
`endif

endmodule
